if_prefetch_unit: RTL and testbench
===================================

IF_PREFETCH_UNIT -- requirements
Module: if_prefetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32: width of all PC/address signals.
REQ-002 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-003 Parameter DEPTH, default 4: prefetch queue entries; power of 2, minimum 2.
REQ-004 CLK  in  1  clock; all state updates on rising edge.
REQ-005 RESET  in  1  reset, asynchronous, active-high.
REQ-006 STALL  in  1  downstream hold (load-use hazard or data-memory busywait); no dequeue while high.
REQ-007 BRANCH_SEL  in  1  redirect request from the branch unit.
REQ-008 B_PC  in  ADDR_W  redirect target.
REQ-009 IC_REQ  out  1  instruction-cache read request.
REQ-010 IC_ADDR  out  ADDR_W  instruction-cache read address.
REQ-011 IC_RDATA  in  32  instruction word from the cache, valid when IC_REQ=1 and IC_BUSYWAIT=0.
REQ-012 IC_BUSYWAIT  in  1  cache busy; response not yet valid.
REQ-013 IF_VALID  out  1  queue head holds a valid instruction.
REQ-014 IF_PC  out  ADDR_W  PC of the queue head.
REQ-015 IF_INSTR  out  32  instruction at the queue head.

Function
REQ-016 Internal fetch PC (FPC) SHALL drive IC_ADDR; bits [1:0] SHALL always be 0.
REQ-017 FSM states: RUN and ABORT; both SHALL leave reset in RUN.
REQ-018 RUN: IC_REQ SHALL be 1 when queue count < DEPTH, and 0 otherwise.
REQ-019 Accept: at a rising edge with IC_REQ=1, IC_BUSYWAIT=0 and no redirect, the unit SHALL push {FPC, IC_RDATA} and set FPC <= FPC+4, wrapping modulo 2^ADDR_W.
REQ-020 Full check SHALL use the current count; with a full queue, no push occurs even in a cycle that pops.
REQ-021 Dequeue SHALL occur at a rising edge with IF_VALID=1, STALL=0 and BRANCH_SEL=0.
REQ-022 When push and dequeue happen on the same edge, count SHALL be unchanged and order SHALL be preserved (FIFO).
REQ-023 IF_VALID SHALL equal (count != 0); IF_PC and IF_INSTR SHALL present the head entry combinationally from the queue storage.
REQ-024 Redirect: on BRANCH_SEL=1 at a rising edge, the unit SHALL flush the queue (count=0) and load FPC <= {B_PC[ADDR_W-1:2],2'b00}, discarding any response accepted on that edge.
REQ-025 A redirect SHALL take priority over push, dequeue and STALL.
REQ-026 If BRANCH_SEL=1 while IC_REQ=1 and IC_BUSYWAIT=1, the unit SHALL instead latch the target into a pending register, flush the queue, and enter ABORT.
REQ-027 ABORT: IC_REQ SHALL stay 1 and IC_ADDR SHALL hold the old address, so the cache never sees an address change mid-miss.
REQ-028 ABORT SHALL be left when IC_BUSYWAIT=0; on that edge the unit SHALL discard the response, set FPC to the pending target, and go to RUN.
REQ-029 A further BRANCH_SEL during ABORT SHALL overwrite the pending target; the last one wins.
REQ-030 IF_VALID SHALL be 0 throughout ABORT.
REQ-031 Fetch throughput SHALL be one instruction per cycle on consecutive cache hits; hit-to-IF_VALID latency SHALL be one edge.

Reset
REQ-032 While RESET=1, the unit SHALL hold FPC=RESET_PC, count=0, state=RUN, pending target=0, IF_VALID=0 and IC_REQ=0, with queue pointers zeroed.
REQ-033 Reset asserted mid-miss or in ABORT SHALL return the unit to the REQ-032 values immediately, without waiting for IC_BUSYWAIT.
REQ-034 The first IC_REQ=1 with IC_ADDR=RESET_PC SHALL appear in the first cycle after RESET deasserts.

Verification
REQ-035 Reset, always-hit cache, STALL=0 -> IF_PC sequence 0,4,8,12… one per cycle, with IF_VALID high from the second cycle.
REQ-036 STALL held 6 cycles with DEPTH=4 -> four entries (PCs 0,4,8,C) queued and IC_REQ=0; STALL release -> dequeued in order, then fetch resumes at 0x10.
REQ-037 BRANCH_SEL with B_PC=0x103 and a hit -> queue flushed, IF_VALID=0 for one cycle, then IF_PC=0x100.
REQ-038 Redirect to 0x200 during a 5-cycle miss on 0x40 -> IC_ADDR holds 0x40 until busywait drops, the 0x40 data is never output, and the next IF_PC=0x200.
REQ-039 Two redirects (0x200 then 0x300) during one miss -> only 0x300 is fetched.
REQ-040 RESET pulse during ABORT -> all outputs reach reset values asynchronously; after release, IC_ADDR=RESET_PC.

Source files
------------

// File: rtl/if_prefetch_unit_if.sv
// rtl/if_prefetch_unit_if.sv - fetch-side bus bundle: pipeline control, i-cache port, IF stage outputs
interface if_prefetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              STALL;
    logic              BRANCH_SEL;
    logic [ADDR_W-1:0] B_PC;
    logic              IC_REQ;
    logic [ADDR_W-1:0] IC_ADDR;
    logic [31:0]       IC_RDATA;
    logic              IC_BUSYWAIT;
    logic              IF_VALID;
    logic [ADDR_W-1:0] IF_PC;
    logic [31:0]       IF_INSTR;

    // master: the prefetch unit itself; slave: pipeline, branch unit and cache around it
    modport master (
        input  STALL, BRANCH_SEL, B_PC, IC_RDATA, IC_BUSYWAIT,
        output IC_REQ, IC_ADDR, IF_VALID, IF_PC, IF_INSTR
    );
    modport slave (
        output STALL, BRANCH_SEL, B_PC, IC_RDATA, IC_BUSYWAIT,
        input  IC_REQ, IC_ADDR, IF_VALID, IF_PC, IF_INSTR
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction prefetch queue with branch redirect and miss-safe abort
module if_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    if_prefetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_M  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] RST_FPC  = RESET_PC & ALIGN_M;

    typedef enum logic {S_RUN, S_ABORT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];

    logic              ic_req;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target;

    // the request is gated by RESET so it drops the instant reset asserts
    assign ic_req = !RESET && ((state_q == S_ABORT) || (count_q < DEPTH_C));
    assign accept = ic_req && !bus.IC_BUSYWAIT;
    assign push   = (state_q == S_RUN) && accept && !bus.BRANCH_SEL;
    assign pop    = (state_q == S_RUN) && (count_q != '0) && !bus.STALL && !bus.BRANCH_SEL;
    assign target = bus.B_PC & ALIGN_M;

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        pend_d   = pend_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        case (state_q)
            S_RUN: begin
                if (bus.BRANCH_SEL) begin
                    count_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    // a miss in flight must finish at its own address before we move
                    if (ic_req && bus.IC_BUSYWAIT) begin
                        pend_d  = target;
                        state_d = S_ABORT;
                    end else begin
                        fpc_d = target;
                    end
                end else begin
                    if (push) begin
                        fpc_d    = fpc_q + ADDR_W'(4);
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                end
            end
            S_ABORT: begin
                if (bus.BRANCH_SEL) begin
                    pend_d = target;
                end
                if (!bus.IC_BUSYWAIT) begin
                    fpc_d   = bus.BRANCH_SEL ? target : pend_q;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_RUN;
            fpc_q    <= RST_FPC;
            pend_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            pend_q   <= pend_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // queue storage needs no reset; validity lives entirely in count_q
    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= fpc_q;
            instr_mem[wr_ptr_q] <= bus.IC_RDATA;
        end
    end

    assign bus.IC_REQ   = ic_req;
    assign bus.IC_ADDR  = fpc_q;
    assign bus.IF_VALID = (count_q != '0);
    assign bus.IF_PC    = pc_mem[rd_ptr_q];
    assign bus.IF_INSTR = instr_mem[rd_ptr_q];
endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - directed self-checking bench for if_prefetch_unit
module tb_if_prefetch_unit;
    logic CLK;
    logic RESET;
    int   errors;
    int   checks;

    if_prefetch_unit_if #(.ADDR_W(32)) bus ();

    if_prefetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    assign bus.IC_RDATA = instr_of(bus.IC_ADDR);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET           = 1'b1;
        bus.STALL       = 1'b0;
        bus.BRANCH_SEL  = 1'b0;
        bus.B_PC        = '0;
        bus.IC_BUSYWAIT = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET           = 1'b1;
        bus.STALL       = 1'b0;
        bus.BRANCH_SEL  = 1'b0;
        bus.B_PC        = '0;
        bus.IC_BUSYWAIT = 1'b0;
        #1;
        checks++; if (bus.IC_REQ !== 1'b0) begin errors++; $display("FAIL rst_ic_req got=%b exp=0", bus.IC_REQ); end
        checks++; if (bus.IF_VALID !== 1'b0) begin errors++; $display("FAIL rst_if_valid got=%b exp=0", bus.IF_VALID); end
        checks++; if (bus.IC_ADDR !== 32'h0) begin errors++; $display("FAIL rst_ic_addr got=%h exp=0", bus.IC_ADDR); end
        tick();
        RESET = 1'b0;
        #1;
        checks++; if (bus.IC_REQ !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", bus.IC_REQ); end
        checks++; if (bus.IC_ADDR !== 32'h0) begin errors++; $display("FAIL first_addr got=%h exp=0", bus.IC_ADDR); end
        checks++; if (bus.IF_VALID !== 1'b0) begin errors++; $display("FAIL first_valid got=%b exp=0", bus.IF_VALID); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (bus.IF_VALID !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, bus.IF_VALID); end
            checks++; if (bus.IF_PC !== 32'(4*k)) begin errors++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, bus.IF_PC, 32'(4*k)); end
            checks++; if (bus.IF_INSTR !== instr_of(32'(4*k))) begin errors++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, bus.IF_INSTR, instr_of(32'(4*k))); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [5];
        exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        do_reset();
        bus.STALL = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        checks++; if (bus.IC_REQ !== 1'b0) begin errors++; $display("FAIL stall_full_req got=%b exp=0", bus.IC_REQ); end
        checks++; if (bus.IC_ADDR !== 32'h10) begin errors++; $display("FAIL stall_full_addr got=%h exp=10", bus.IC_ADDR); end
        checks++; if (bus.IF_PC !== 32'h0 || bus.IF_VALID !== 1'b1) begin errors++; $display("FAIL stall_head got=%h/%b exp=0/1", bus.IF_PC, bus.IF_VALID); end
        bus.STALL = 1'b0;
        tick();
        checks++; if (bus.IC_ADDR !== 32'h10) begin errors++; $display("FAIL full_pop_nopush got=%h exp=10", bus.IC_ADDR); end
        checks++; if (bus.IF_PC !== exp_pc[0]) begin errors++; $display("FAIL drain_pc0 got=%h exp=%h", bus.IF_PC, exp_pc[0]); end
        for (int k = 1; k < 5; k++) begin
            tick();
            checks++; if (bus.IF_PC !== exp_pc[k]) begin errors++; $display("FAIL drain_pc k=%0d got=%h exp=%h", k, bus.IF_PC, exp_pc[k]); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 3; k++) tick();
        bus.BRANCH_SEL = 1'b1;
        bus.B_PC       = 32'h103;
        bus.STALL      = 1'b1;
        tick();
        bus.BRANCH_SEL = 1'b0;
        bus.STALL      = 1'b0;
        checks++; if (bus.IF_VALID !== 1'b0) begin errors++; $display("FAIL redir_flush got=%b exp=0", bus.IF_VALID); end
        checks++; if (bus.IC_ADDR !== 32'h100) begin errors++; $display("FAIL redir_addr got=%h exp=100", bus.IC_ADDR); end
        tick();
        checks++; if (bus.IF_VALID !== 1'b1 || bus.IF_PC !== 32'h100) begin errors++; $display("FAIL redir_pc got=%h/%b exp=100/1", bus.IF_PC, bus.IF_VALID); end
        checks++; if (bus.IF_INSTR !== instr_of(32'h100)) begin errors++; $display("FAIL redir_instr got=%h exp=%h", bus.IF_INSTR, instr_of(32'h100)); end
        tick();
        checks++; if (bus.IF_PC !== 32'h104) begin errors++; $display("FAIL redir_next got=%h exp=104", bus.IF_PC); end
    endtask

    task automatic test_abort();
        do_reset();
        for (int k = 0; k < 16; k++) tick();
        checks++; if (bus.IC_ADDR !== 32'h40) begin errors++; $display("FAIL abort_pre_addr got=%h exp=40", bus.IC_ADDR); end
        bus.IC_BUSYWAIT = 1'b1;
        tick();
        bus.BRANCH_SEL = 1'b1;
        bus.B_PC       = 32'h200;
        tick();
        bus.BRANCH_SEL = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.IC_ADDR !== 32'h40 || bus.IC_REQ !== 1'b1) begin errors++; $display("FAIL abort_hold k=%0d got=%h/%b exp=40/1", k, bus.IC_ADDR, bus.IC_REQ); end
            checks++; if (bus.IF_VALID !== 1'b0) begin errors++; $display("FAIL abort_valid k=%0d got=%b exp=0", k, bus.IF_VALID); end
            if (k == 2) bus.IC_BUSYWAIT = 1'b0;
            tick();
        end
        checks++; if (bus.IC_ADDR !== 32'h200 || bus.IF_VALID !== 1'b0) begin errors++; $display("FAIL abort_exit got=%h/%b exp=200/0", bus.IC_ADDR, bus.IF_VALID); end
        tick();
        checks++; if (bus.IF_PC !== 32'h200 || bus.IF_VALID !== 1'b1) begin errors++; $display("FAIL abort_target got=%h/%b exp=200/1", bus.IF_PC, bus.IF_VALID); end
    endtask

    task automatic test_double_redirect();
        do_reset();
        bus.IC_BUSYWAIT = 1'b1;
        bus.BRANCH_SEL  = 1'b1;
        bus.B_PC        = 32'h200;
        tick();
        bus.B_PC = 32'h300;
        tick();
        checks++; if (bus.IC_ADDR !== 32'h0) begin errors++; $display("FAIL dbl_hold got=%h exp=0", bus.IC_ADDR); end
        bus.BRANCH_SEL  = 1'b0;
        bus.IC_BUSYWAIT = 1'b0;
        tick();
        checks++; if (bus.IC_ADDR !== 32'h300) begin errors++; $display("FAIL dbl_addr got=%h exp=300", bus.IC_ADDR); end
        tick();
        checks++; if (bus.IF_PC !== 32'h300 || bus.IF_VALID !== 1'b1) begin errors++; $display("FAIL dbl_pc got=%h/%b exp=300/1", bus.IF_PC, bus.IF_VALID); end
    endtask

    task automatic test_reset_in_abort();
        do_reset();
        tick();
        tick();
        bus.IC_BUSYWAIT = 1'b1;
        bus.BRANCH_SEL  = 1'b1;
        bus.B_PC        = 32'h500;
        tick();
        bus.BRANCH_SEL = 1'b0;
        checks++; if (bus.IC_ADDR !== 32'h8 || bus.IF_VALID !== 1'b0) begin errors++; $display("FAIL ra_abort got=%h/%b exp=8/0", bus.IC_ADDR, bus.IF_VALID); end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (bus.IC_REQ !== 1'b0 || bus.IF_VALID !== 1'b0 || bus.IC_ADDR !== 32'h0) begin errors++; $display("FAIL ra_async got=%b/%b/%h exp=0/0/0", bus.IC_REQ, bus.IF_VALID, bus.IC_ADDR); end
        tick();
        RESET = 1'b0;
        #1;
        checks++; if (bus.IC_REQ !== 1'b1 || bus.IC_ADDR !== 32'h0) begin errors++; $display("FAIL ra_release got=%b/%h exp=1/0", bus.IC_REQ, bus.IC_ADDR); end
        bus.IC_BUSYWAIT = 1'b0;
        tick();
        checks++; if (bus.IF_PC !== 32'h0 || bus.IF_VALID !== 1'b1) begin errors++; $display("FAIL ra_fetch got=%h/%b exp=0/1", bus.IF_PC, bus.IF_VALID); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_abort();
        test_double_redirect();
        test_reset_in_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
